// File: rtl/qcw_bridge_driver.sv
// Full-bridge gate sequencer for the QCW inverter: follows the PLL phase, inserts dead time,
// starts/stops bursts on cycle boundaries and shuts down on fault or half-cycle watchdog.
module qcw_bridge_driver #(
    parameter int DEADTIME = 10,
    parameter int MAX_HALF = 2000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phase_in,
    input  logic             enable,
    input  logic             fault_in,
    input  logic             fault_clear,
    output logic             gate_ah,
    output logic             gate_bl,
    output logic             gate_al,
    output logic             gate_bh,
    output logic             running,
    output logic             fault,
    output logic             wdog_trip,
    output logic [CNT_W-1:0] cycle_count
);

    // state   | meaning
    // S_IDLE  | gates off, waiting for enable
    // S_ARM   | burst requested, waiting for first phase rise
    // S_POS   | diagonal P (ah/bl) driven
    // S_DEAD  | both diagonals off between halves
    // S_NEG   | diagonal N (al/bh) driven
    // S_STOP  | closing dead time after the last NEG half
    // S_FAULT | latched shutdown until cleared with enable low

    localparam int HW = $clog2(MAX_HALF + 1);
    localparam int DW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_POS, S_DEAD, S_NEG, S_STOP, S_FAULT
    } state_t;

    state_t           state, state_nx;
    logic             p_q, p_d;
    logic             rise, fall;
    logic [DW-1:0]    dead_cnt;
    logic [HW-1:0]    half_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             wdog_q;
    logic             wdog_hit, wdog_set, cnt_inc;
    logic             in_half;

    assign rise     = p_q & ~p_d;
    assign fall     = ~p_q & p_d;
    assign in_half  = (state == S_POS) || (state == S_NEG);
    assign wdog_hit = in_half && (half_cnt == HW'(MAX_HALF));

    always_comb begin
        state_nx = state;
        wdog_set = 1'b0;
        cnt_inc  = 1'b0;
        if (fault_in) begin
            state_nx = S_FAULT;
        end else if (wdog_hit) begin
            state_nx = S_FAULT;
            wdog_set = 1'b1;
        end else begin
            case (state)
                S_IDLE:  if (enable) state_nx = S_ARM;
                S_ARM: begin
                    if (!enable)   state_nx = S_IDLE;
                    else if (rise) state_nx = S_POS;
                end
                S_POS:   if (fall) state_nx = S_DEAD;
                S_NEG: begin
                    if (rise) begin
                        cnt_inc  = 1'b1;
                        state_nx = enable ? S_DEAD : S_STOP;
                    end
                end
                // Landing side follows the live phase, so a glitch returns to the same half.
                S_DEAD:  if (dead_cnt == '0) state_nx = p_q ? S_POS : S_NEG;
                S_STOP:  if (dead_cnt == '0) state_nx = S_IDLE;
                S_FAULT: if (fault_clear && !enable) state_nx = S_IDLE;
                default: state_nx = S_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            p_q      <= 1'b0;
            p_d      <= 1'b0;
            dead_cnt <= '0;
            half_cnt <= '0;
            cyc_cnt  <= '0;
            wdog_q   <= 1'b0;
        end else begin
            state <= state_nx;
            p_q   <= phase_in;
            p_d   <= p_q;

            if (state_nx != state && (state_nx == S_DEAD || state_nx == S_STOP))
                dead_cnt <= DW'(DEADTIME - 1);
            else if (dead_cnt != '0)
                dead_cnt <= dead_cnt - 1'b1;

            // half_cnt holds the 1-based cycle index within the current half
            if (state_nx != state && (state_nx == S_POS || state_nx == S_NEG))
                half_cnt <= HW'(1);
            else if (in_half && half_cnt != HW'(MAX_HALF))
                half_cnt <= half_cnt + 1'b1;

            if (state == S_IDLE && state_nx == S_ARM)
                cyc_cnt <= '0;
            else if (cnt_inc && cyc_cnt != '1)
                cyc_cnt <= cyc_cnt + 1'b1;

            if (wdog_set)
                wdog_q <= 1'b1;
            else if (state == S_FAULT && state_nx == S_IDLE)
                wdog_q <= 1'b0;
        end
    end

    assign gate_ah     = (state == S_POS);
    assign gate_bl     = (state == S_POS);
    assign gate_al     = (state == S_NEG);
    assign gate_bh     = (state == S_NEG);
    assign running     = (state == S_ARM) || (state == S_POS) ||
                         (state == S_NEG) || (state == S_DEAD);
    assign fault       = (state == S_FAULT);
    assign wdog_trip   = wdog_q;
    assign cycle_count = cyc_cnt;

endmodule

// File: tb/tb_qcw_bridge_driver.sv
// Directed bench for qcw_bridge_driver: burst timing, stop, glitch, watchdog, fault, reset, saturation.
module tb_qcw_bridge_driver;

    localparam int DT    = 10;
    localparam int MH    = 2000;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          phase_in = 1'b0;
    logic          enable = 1'b0;
    logic          fault_in = 1'b0;
    logic          fault_clear = 1'b0;
    logic          gate_ah, gate_bl, gate_al, gate_bh;
    logic          running, fault, wdog_trip;
    logic [CW-1:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    int overlap = 0, pair_err = 0;
    int p_run = 0, n_run = 0, gap_run = 0;
    int p_len = 0, n_len = 0, gap_len = 0;
    int n_starts = 0;
    logic n_prev = 1'b0;
    int nst;

    qcw_bridge_driver #(.DEADTIME(DT), .MAX_HALF(MH), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .phase_in    (phase_in),
        .enable      (enable),
        .fault_in    (fault_in),
        .fault_clear (fault_clear),
        .gate_ah     (gate_ah),
        .gate_bl     (gate_bl),
        .gate_al     (gate_al),
        .gate_bh     (gate_bh),
        .running     (running),
        .fault       (fault),
        .wdog_trip   (wdog_trip),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run-length monitor of the gate waveforms, sampled mid-cycle.
    always @(negedge clk) begin
        if (gate_ah && gate_al) overlap++;
        if (gate_ah != gate_bl || gate_al != gate_bh) pair_err++;
        if (gate_ah) p_run++;
        else if (p_run != 0) begin p_len = p_run; p_run = 0; end
        if (gate_al) n_run++;
        else if (n_run != 0) begin n_len = n_run; n_run = 0; end
        if (!gate_ah && !gate_al && running) gap_run++;
        else if (gap_run != 0) begin gap_len = gap_run; gap_run = 0; end
        if (gate_al && !n_prev) n_starts++;
        n_prev = gate_al;
    end

    initial begin
        tick(3);
        chk("rst_gate_ah", gate_ah, 0);
        chk("rst_gate_al", gate_al, 0);
        chk("rst_running", running, 0);
        chk("rst_fault", fault, 0);
        chk("rst_wdog", wdog_trip, 0);
        chk("rst_count", cycle_count, 0);

        // burst with 940-cycle period
        rst = 1'b0;
        enable = 1'b1;
        tick(5);
        chk("arm_running", running, 1);
        chk("arm_no_gate", gate_ah, 0);
        phase_in = 1'b1;
        tick(1);
        chk("lat_edge1", gate_ah, 0);
        tick(1);
        chk("lat_edge2", gate_ah, 1);
        tick(468);
        phase_in = 1'b0;
        tick(470);
        repeat (2) begin
            phase_in = 1'b1; tick(470);
            phase_in = 1'b0; tick(470);
        end
        chk("p_half_len", p_len, 460);
        chk("n_half_len", n_len, 460);
        chk("dead_len", gap_len, DT);
        chk("burst_count", cycle_count, 2);

        // drop enable mid-POS
        phase_in = 1'b1;
        tick(100);
        enable = 1'b0;
        tick(370);
        phase_in = 1'b0;
        tick(470);
        phase_in = 1'b1;
        tick(1);
        chk("last_neg", gate_al, 1);
        tick(1);
        chk("stop_running", running, 0);
        chk("stop_gate_al", gate_al, 0);
        chk("stop_count", cycle_count, 4);
        enable = 1'b1;
        tick(9);
        chk("stop_hold", running, 0);
        tick(1);
        chk("stop_idle", running, 0);
        tick(1);
        chk("rearm", running, 1);
        chk("rearm_count_clr", cycle_count, 0);

        // 3-cycle glitch low inside POS
        phase_in = 1'b0;
        tick(5);
        phase_in = 1'b1;
        tick(2);
        chk("glitch_pos", gate_ah, 1);
        tick(50);
        nst = n_starts;
        phase_in = 1'b0;
        tick(2);
        chk("glitch_dead", gate_ah, 0);
        chk("glitch_no_n", gate_al, 0);
        tick(1);
        phase_in = 1'b1;
        tick(8);
        chk("glitch_dead_end", gate_ah, 0);
        tick(1);
        chk("glitch_back_pos", gate_ah, 1);
        chk("glitch_n_starts", n_starts, nst);

        // watchdog: phase stuck high
        tick(1999);
        chk("wd_before", gate_ah, 1);
        chk("wd_before_fault", fault, 0);
        tick(1);
        chk("wd_gate_off", gate_ah, 0);
        chk("wd_fault", fault, 1);
        chk("wd_trip", wdog_trip, 1);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        chk("wd_clear_en_hi", fault, 1);
        enable = 1'b0;
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        chk("wd_cleared", fault, 0);
        chk("wd_trip_cleared", wdog_trip, 0);

        // external fault during NEG
        enable = 1'b1;
        phase_in = 1'b0;
        tick(3);
        phase_in = 1'b1;
        tick(30);
        phase_in = 1'b0;
        tick(50);
        chk("ext_in_neg", gate_al, 1);
        fault_in = 1'b1;
        tick(1);
        fault_in = 1'b0;
        chk("ext_gate_off", gate_al, 0);
        chk("ext_fault", fault, 1);
        chk("ext_no_wdog", wdog_trip, 0);
        enable = 1'b0;
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        chk("ext_cleared", fault, 0);

        // saturation with 40-cycle period, then reset mid-burst
        enable = 1'b1;
        tick(3);
        repeat (100) begin
            phase_in = 1'b1; tick(20);
            phase_in = 1'b0; tick(20);
        end
        chk("count_99", cycle_count, 99);
        repeat (200) begin
            phase_in = 1'b1; tick(20);
            phase_in = 1'b0; tick(20);
        end
        chk("count_sat", cycle_count, 255);
        chk("sat_in_neg", gate_al, 1);
        rst = 1'b1;
        tick(1);
        chk("midrst_gate", gate_al, 0);
        chk("midrst_running", running, 0);
        chk("midrst_count", cycle_count, 0);
        rst = 1'b0;
        enable = 1'b0;

        // fault from IDLE, clear blocked while fault_in persists
        fault_in = 1'b1;
        tick(1);
        chk("idle_fault", fault, 1);
        fault_clear = 1'b1;
        tick(1);
        chk("clear_blocked", fault, 1);
        fault_in = 1'b0;
        tick(1);
        fault_clear = 1'b0;
        chk("clear_ok", fault, 0);

        chk("no_overlap", overlap, 0);
        chk("pair_match", pair_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
